// File: rtl/aib_hrdrst_seq.sv
// ---------------------------------------------------------------------------
// aib_hrdrst_seq
//
// This block sequences the AIB hard-reset handshake through three phases:
// OSC, then TX, then RX. For each phase it does the following:
//   - waits a settle period,
//   - raises that phase's master transfer enable,
//   - waits for the matching slave acknowledgement.
// Master enables of completed phases stay high, so the enables only ever
// accumulate until the sequence is aborted or reset.
//
// Optional feature (build macro AIB_HRDRST_SEQ_TIMEOUT_EN):
//   When this macro is defined, the block adds a per-phase timeout with a
//   retry budget and an error state. If an attempt times out, the block
//   drops that phase's enable and retries after a fresh settle period.
//   When the macro is undefined, the block waits for each acknowledgement
//   indefinitely. In that build o_err and o_retry_cnt are tied to 0.
//
// Parameters:
//   WAIT_CYC     settle time before each master enable (1..65535)
//   TIMEOUT_CYC  cycles one attempt may wait for the slave (2..65535)
//   MAX_RETRY    failed attempts per phase before error (1..15)
//
// Ports:
//   i_aux_clk               block clock
//   i_rst_n                 asynchronous active-low reset
//   i_start                 level request; low aborts back to IDLE
//   c_sl_*_transfer_en      slave acknowledgements (already on i_aux_clk)
//   c_ms_*_transfer_en      registered master enables
//   o_phase                 0=OSC 1=TX 2=RX 3=complete
//   o_retry_cnt             failed attempts in the current phase
//   o_done                  all three phases acknowledged
//   o_err                   retry budget exhausted
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for i_start
// WAIT_CLK | settle countdown before raising the current phase's enable
// WAIT_SL  | enable raised, waiting for the slave acknowledgement
// DONE     | all phases acknowledged, held while i_start stays high
// ERR      | retry budget exhausted, held while i_start stays high
// ---------------------------------------------------------------------------
module aib_hrdrst_seq #(
    parameter int WAIT_CYC    = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_RETRY   = 3
) (
    input  logic       i_aux_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       c_sl_osc_transfer_en,
    input  logic       c_sl_tx_transfer_en,
    input  logic       c_sl_rx_transfer_en,
    output logic       c_ms_osc_transfer_en,
    output logic       c_ms_tx_transfer_en,
    output logic       c_ms_rx_transfer_en,
    output logic [1:0] o_phase,
    output logic [3:0] o_retry_cnt,
    output logic       o_done,
    output logic       o_err
);

    if (WAIT_CYC < 1 || WAIT_CYC > 65535 ||
        TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535 ||
        MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_param
        $error("aib_hrdrst_seq: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CLK,
        WAIT_SL,
        DONE,
        ERR
    } state_t;

    localparam logic [15:0] WAIT_LOAD = 16'(WAIT_CYC - 1);

    state_t      state;
    logic [1:0]  phase;
    logic [2:0]  ms_en;
    logic [15:0] wait_cnt;
    logic        wait_tc;
    logic [2:0]  phase_mask;
    logic        sl_cur;

`ifdef AIB_HRDRST_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY - 1);
    logic [15:0] tmo_cnt;
    logic [3:0]  retry;
`endif

    // The settle terminal count is registered so the zero-compare stays off
    // the enable path. Because of that extra register stage, the enable rises
    // WAIT_CYC+1 edges after the counter is loaded.
    always_comb begin
        phase_mask = 3'b000;
        sl_cur     = 1'b0;
        case (phase)
            2'd0: begin
                phase_mask = 3'b001;
                sl_cur     = c_sl_osc_transfer_en;
            end
            2'd1: begin
                phase_mask = 3'b010;
                sl_cur     = c_sl_tx_transfer_en;
            end
            2'd2: begin
                phase_mask = 3'b100;
                sl_cur     = c_sl_rx_transfer_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_aux_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            phase    <= 2'd0;
            ms_en    <= 3'b000;
            wait_cnt <= 16'd0;
            wait_tc  <= 1'b0;
`ifdef AIB_HRDRST_SEQ_TIMEOUT_EN
            tmo_cnt  <= 16'd0;
            retry    <= 4'd0;
`endif
        end else if (state != IDLE && !i_start) begin
            state    <= IDLE;
            phase    <= 2'd0;
            ms_en    <= 3'b000;
            wait_cnt <= 16'd0;
            wait_tc  <= 1'b0;
`ifdef AIB_HRDRST_SEQ_TIMEOUT_EN
            tmo_cnt  <= 16'd0;
            retry    <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state    <= WAIT_CLK;
                        phase    <= 2'd0;
                        wait_cnt <= WAIT_LOAD;
                        wait_tc  <= 1'b0;
`ifdef AIB_HRDRST_SEQ_TIMEOUT_EN
                        retry    <= 4'd0;
`endif
                    end
                end
                WAIT_CLK: begin
                    if (wait_tc) begin
                        state   <= WAIT_SL;
                        ms_en   <= ms_en | phase_mask;
                        wait_tc <= 1'b0;
`ifdef AIB_HRDRST_SEQ_TIMEOUT_EN
                        tmo_cnt <= TMO_LOAD;
`endif
                    end else begin
                        wait_tc <= (wait_cnt == 16'd0);
                        if (wait_cnt != 16'd0) begin
                            wait_cnt <= wait_cnt - 16'd1;
                        end
                    end
                end
                WAIT_SL: begin
                    // An acknowledgement in the timeout cycle wins over the timeout.
                    if (sl_cur) begin
                        if (phase == 2'd2) begin
                            state <= DONE;
                            phase <= 2'd3;
                        end else begin
                            state    <= WAIT_CLK;
                            phase    <= phase + 2'd1;
                            wait_cnt <= WAIT_LOAD;
                            wait_tc  <= 1'b0;
`ifdef AIB_HRDRST_SEQ_TIMEOUT_EN
                            retry    <= 4'd0;
`endif
                        end
                    end
`ifdef AIB_HRDRST_SEQ_TIMEOUT_EN
                    else if (tmo_cnt == 16'd0) begin
                        ms_en <= ms_en & ~phase_mask;
                        retry <= retry + 4'd1;
                        if (retry == RETRY_MAX) begin
                            state <= ERR;
                        end else begin
                            state    <= WAIT_CLK;
                            wait_cnt <= WAIT_LOAD;
                            wait_tc  <= 1'b0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt - 16'd1;
                    end
`endif
                end
                DONE: ;
                ERR:  ;
                default: state <= IDLE;
            endcase
        end
    end

    assign c_ms_osc_transfer_en = ms_en[0];
    assign c_ms_tx_transfer_en  = ms_en[1];
    assign c_ms_rx_transfer_en  = ms_en[2];
    assign o_phase              = phase;
    assign o_done               = (state == DONE);

`ifdef AIB_HRDRST_SEQ_TIMEOUT_EN
    assign o_retry_cnt = retry;
    assign o_err       = (state == ERR);
`else
    assign o_retry_cnt = 4'd0;
    assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_aib_hrdrst_seq.sv
module tb_aib_hrdrst_seq;

    localparam int WAIT_CYC    = 16;
    localparam int TIMEOUT_CYC = 8;
    localparam int MAX_RETRY   = 3;
`ifdef AIB_HRDRST_SEQ_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] echo_mask = 3'b000;
    logic [2:0] sl_force  = 3'b000;
    logic [2:0] ms_q      = 3'b000;
    logic [2:0] sl;
    logic       ms_osc, ms_tx, ms_rx;
    logic [2:0] ms;
    logic [1:0] phase;
    logic [3:0] retry;
    logic       done, err;
    logic [4:0] obs;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave echoes each master enable one cycle later (per echo_mask), plus forced bits.
    always @(negedge clk) ms_q <= ms;
    assign sl  = (ms_q & echo_mask) | sl_force;
    assign ms  = {ms_rx, ms_tx, ms_osc};
    assign obs = {err, done, ms_rx, ms_tx, ms_osc};

    aib_hrdrst_seq #(
        .WAIT_CYC   (WAIT_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .i_aux_clk           (clk),
        .i_rst_n             (rst_n),
        .i_start             (start),
        .c_sl_osc_transfer_en(sl[0]),
        .c_sl_tx_transfer_en (sl[1]),
        .c_sl_rx_transfer_en (sl[2]),
        .c_ms_osc_transfer_en(ms_osc),
        .c_ms_tx_transfer_en (ms_tx),
        .c_ms_rx_transfer_en (ms_rx),
        .o_phase             (phase),
        .o_retry_cnt         (retry),
        .o_done              (done),
        .o_err               (err)
    );

    function automatic void check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference model: time is counted in edges since the current attempt
    // started (t=0 at the start/ack/timeout edge). The enable is up once
    // t reaches WAIT_CYC+1, and the attempt expires TIMEOUT_CYC edges later.
    int         m_st    = 0;   // 0 idle, 1 running, 2 done, 3 error
    int         m_phase = 0;
    int         m_retry = 0;
    int         m_t     = 0;
    logic [2:0] m_en    = 3'b000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_phase = 0; m_retry = 0; m_t = 0; m_en = 3'b000;
        end else if (m_st == 0) begin
            if (start) begin
                m_st = 1; m_phase = 0; m_retry = 0; m_t = 0; m_en = 3'b000;
            end
        end else if (!start) begin
            m_st = 0; m_phase = 0; m_retry = 0; m_t = 0; m_en = 3'b000;
        end else if (m_st == 1) begin
            if (m_t > WAIT_CYC && sl[m_phase]) begin
                if (m_phase == 2) begin
                    m_st = 2; m_phase = 3;
                end else begin
                    m_phase = m_phase + 1; m_retry = 0; m_t = 0;
                end
            end else if (TMO && m_t == WAIT_CYC + TIMEOUT_CYC) begin
                m_en[m_phase] = 1'b0;
                m_retry = m_retry + 1;
                if (m_retry == MAX_RETRY) m_st = 3;
                else m_t = 0;
            end else begin
                m_t = m_t + 1;
                if (m_t == WAIT_CYC + 1) m_en[m_phase] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("ms_en", int'(ms), int'(m_en));
        check("phase", int'(phase), m_phase);
        check("retry", int'(retry), m_retry);
        check("done",  int'(done), int'(m_st == 2));
        check("err",   int'(err),  int'(m_st == 3));
    end

    task automatic set_sl_ctl(input logic [2:0] mask, input logic [2:0] frc);
        echo_mask = mask;
        sl_force  = frc;
    endtask

    // Waits for obs[idx] high; returns the edge index seen at that negedge.
    task automatic wait_bit(input int idx, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (obs[idx]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL wait_obs%0d: no rise within %0d cycles", idx, bound);
        end
    endtask

    task automatic stop_seq();
        start = 1'b0;
        @(negedge clk);
        check("abort_ms", int'(ms), 0);
        check("abort_phase", int'(phase), 0);
        set_sl_ctl(3'b000, 3'b000);
        @(negedge clk);
    endtask

    initial begin
        int c0, r, r2, r3, n, falls;
        logic prev;
        logic [15:0] seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ms", int'(ms), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_retry", int'(retry), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full sequence with immediate echoes
        set_sl_ctl(3'b111, 3'b000);
        start = 1'b1;
        c0 = cyc;
        wait_bit(0, 100, r);
        check("osc_latency", r - c0, 18);
        wait_bit(1, 100, r2);
        check("tx_after_ack", r2 - r, 18);
        wait_bit(2, 100, r3);
        check("rx_after_ack", r3 - r2, 18);
        wait_bit(3, 20, n);
        check("done_flag", int'(done), 1);
        check("done_phase", int'(phase), 3);
        check("done_ms", int'(ms), 7);
        stop_seq();

        // Abort while waiting for TX acknowledgement, then rerun
        set_sl_ctl(3'b001, 3'b000);
        start = 1'b1;
        wait_bit(1, 100, r);
        repeat (2) @(negedge clk);
        check("pre_abort_phase", int'(phase), 1);
        start = 1'b0;
        @(negedge clk);
        check("abort_ms_all", int'(ms), 0);
        check("abort_phase0", int'(phase), 0);
        set_sl_ctl(3'b111, 3'b000);
        start = 1'b1;
        c0 = cyc;
        wait_bit(0, 100, r);
        check("rerun_latency", r - c0, 18);
        wait_bit(3, 200, n);
        check("rerun_done", int'(done), 1);
        stop_seq();

        // Async reset pulse while settling in phase 1
        set_sl_ctl(3'b111, 3'b000);
        start = 1'b1;
        wait_bit(0, 100, r);
        repeat (5) @(negedge clk);
        check("pre_rst_phase", int'(phase), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_ms", int'(ms), 0);
        check("async_phase", int'(phase), 0);
        #4 rst_n = 1'b1;
        c0 = cyc;
        wait_bit(0, 100, r);
        check("restart_latency", r - c0, 18);
        wait_bit(3, 200, n);
        check("restart_done", int'(done), 1);
        stop_seq();

`ifdef AIB_HRDRST_SEQ_TIMEOUT_EN
        // TX never acknowledged: three attempts, then error
        set_sl_ctl(3'b001, 3'b000);
        start = 1'b1;
        n = 0; prev = 1'b0; seen = '0;
        for (int i = 0; i < 400 && !err; i++) begin
            @(negedge clk);
            if (ms_tx && !prev) n++;
            prev = ms_tx;
            seen[retry] = 1'b1;
        end
        check("tx_pulses", n, 3);
        check("retry_seen1", int'(seen[1]), 1);
        check("retry_seen2", int'(seen[2]), 1);
        check("err_flag", int'(err), 1);
        check("err_ms", int'(ms), 1);
        check("err_retry", int'(retry), 3);
        stop_seq();

        // TX acknowledgement lands exactly in the timeout cycle
        set_sl_ctl(3'b001, 3'b000);
        start = 1'b1;
        wait_bit(1, 100, r);
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        set_sl_ctl(3'b101, 3'b010);
        falls = 0; prev = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!ms_tx && prev) falls++;
            prev = ms_tx;
        end
        check("tx_no_drop", falls, 0);
        check("race_retry", int'(retry), 0);
        check("race_done", int'(done), 1);
        check("race_phase", int'(phase), 3);
        stop_seq();
`else
        // OSC acknowledgement withheld for a long time: no error, still completes
        set_sl_ctl(3'b000, 3'b000);
        start = 1'b1;
        repeat (5000) @(negedge clk);
        check("long_err", int'(err), 0);
        check("long_ms", int'(ms), 1);
        check("long_phase", int'(phase), 0);
        set_sl_ctl(3'b111, 3'b000);
        wait_bit(3, 200, n);
        check("long_done", int'(done), 1);
        check("long_retry", int'(retry), 0);
        stop_seq();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aib_hrdrst_seq.md
AIB_HRDRST_SEQ -- requirements
Module: aib_hrdrst_seq

Interface
REQ-001 Parameter WAIT_CYC, default 16, meaning settle cycles before each phase's master enable is raised (range 1..65535).
REQ-002 Parameter TIMEOUT_CYC, default 1024, meaning cycles allowed in one phase for the slave enable to arrive (range 2..65535).
REQ-003 Parameter MAX_RETRY, default 3, meaning failed attempts per phase before error (range 1..15).
REQ-004 i_aux_clk  input  1  meaning single clock for the entire block.
REQ-005 i_rst_n  input  1  meaning asynchronous, active-low reset.
REQ-006 i_start  input  1  meaning level request to run the hard-reset sequence; low aborts.
REQ-007 c_sl_osc_transfer_en / c_sl_tx_transfer_en / c_sl_rx_transfer_en  input  1 each  meaning slave phase acknowledgements, already synchronous to i_aux_clk.
REQ-008 c_ms_osc_transfer_en / c_ms_tx_transfer_en / c_ms_rx_transfer_en  output  1 each  meaning master phase enables, registered.
REQ-009 o_phase  output  2  meaning current phase (0=OSC, 1=TX, 2=RX, 3=complete).
REQ-010 o_retry_cnt  output  4  meaning failed attempts in current phase.
REQ-011 o_done  output  1  meaning all three phases acknowledged.
REQ-012 o_err  output  1  meaning retry budget exhausted.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT_CLK, WAIT_SL, DONE and ERR; o_done SHALL equal (state==DONE) and o_err SHALL equal (state==ERR).
REQ-014 IDLE with i_start=1 SHALL go to WAIT_CLK with phase=0, retry=0 and the wait counter loaded to WAIT_CYC-1.
REQ-015 WAIT_CLK SHALL decrement the counter each cycle and, when the counter is 0, go to WAIT_SL, set the current phase's master enable, and clear the timeout counter.
REQ-016 The first master enable (c_ms_osc_transfer_en) SHALL rise exactly WAIT_CYC+1 clock edges after the edge that first samples i_start=1 in IDLE.
REQ-017 WAIT_SL with the current phase's slave enable high SHALL do one of the following: advance phase, clear retry and reload the wait counter into WAIT_CLK; or, when in phase 2, go to DONE with o_phase=3.
REQ-018 Master enables of completed phases SHALL remain high until abort or reset (cumulative, monotonic).
REQ-019 WAIT_SL SHALL count cycles; on reaching TIMEOUT_CYC-1 without acknowledgement it SHALL drop only the current phase's master enable and increment retry.
REQ-020 After a timeout, the FSM SHALL enter ERR if the incremented retry equals MAX_RETRY, else re-enter WAIT_CLK with the wait counter reloaded.
REQ-021 When acknowledgement and timeout occur in the same cycle, acknowledgement SHALL win.
REQ-022 Slave enables of non-current phases SHALL be ignored.
REQ-023 i_start=0 in any non-IDLE state SHALL, on the next edge, return to IDLE with all master enables, counters, phase and retry cleared.
REQ-024 DONE and ERR SHALL be held while i_start=1; ERR SHALL retain the failing phase's enables (lower phases high, failing phase low).

Reset
REQ-025 Asserting i_rst_n low SHALL asynchronously force IDLE, all master enables 0, o_phase=0, o_retry_cnt=0, o_done=0, o_err=0, and all counters 0.
REQ-026 Reset asserted mid-sequence SHALL override all other inputs; after release the block SHALL restart only when IDLE samples i_start=1.

Configuration
REQ-027 With macro AIB_HRDRST_SEQ_TIMEOUT_EN defined, the timeout counter, retry logic and ERR state SHALL be implemented per REQ-019..REQ-021 and REQ-024.
REQ-028 Without AIB_HRDRST_SEQ_TIMEOUT_EN, WAIT_SL SHALL wait indefinitely, o_err SHALL be tied 0, o_retry_cnt SHALL be tied 0, and no timeout counter SHALL be present.

Verification
REQ-029 Defaults, i_start=1 and all slave enables echoed 1 cycle after the master enables -> ms_osc rises 17 edges after start, ms_tx and ms_rx follow 17 edges after each ack, and o_done=1 with o_phase=3.
REQ-030 TIMEOUT_EN defined, TIMEOUT_CYC=8, sl_tx never asserted -> ms_tx pulses 3 times, o_retry_cnt steps 1 and 2, then o_err=1 with ms_osc=1 and ms_tx=0.
REQ-031 sl_tx first asserted in the cycle the timeout would fire -> phase advances to 1→2, retry stays 0, no ms_tx drop.
REQ-032 i_start dropped while in WAIT_SL of phase 1 -> next edge: IDLE, all ms enables 0, o_phase=0; reasserting i_start reruns from OSC.
REQ-033 i_rst_n pulsed low for half a cycle during WAIT_CLK -> outputs clear immediately (asynchronously) and the sequence restarts from IDLE.
REQ-034 TIMEOUT_EN undefined, sl_osc withheld 5000 cycles then asserted -> no error, the sequence completes, and o_done=1.
